pool1_layer: RTL and testbench

2×2 stride-2 max-pooling stage placed directly downstream of the first convolution layer of the CIFAR-10 quantized pipeline. It consumes that layer's 128-bit output blob stream (8 signed 16-bit channels per beat) over the blob en/eop/rdy handshake. It emits the pooled blob in the same format to the next layer. A single line buffer holds horizontal maxima of even rows, so the block needs no external memory.

---
 rtl/pool1_pkg.sv | 36 +++
 rtl/pool1_layer_if.sv | 12 +
 rtl/pool1_line_buf.sv | 36 +++
 rtl/pool1_layer.sv | 177 +++++++++++++++++
 tb/tb_pool1_layer.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool1_pkg.sv
// pool1_pkg: shared types, constants and lane helpers for the pool1 max-pooling stage.
//   lane_t / beat_t : one signed DW-bit lane / one KPF-lane beat
//   pool_state_e    : RUN/HOLD output-stall state
//   *_DEF, W_OUT, H_OUT, *_BEATS_PER_FRAME : default geometry and derived frame sizes
package pool1_pkg;

    localparam int unsigned KPF    = 8;
    localparam int unsigned DW     = 16;
    localparam int unsigned BEAT_W = KPF * DW;

    localparam int unsigned W_IN_DEF     = 32;
    localparam int unsigned H_IN_DEF     = 32;
    localparam int unsigned C_GROUPS_DEF = 4;

    localparam int unsigned W_OUT = W_IN_DEF / 2;
    localparam int unsigned H_OUT = H_IN_DEF / 2;
    localparam int unsigned IN_BEATS_PER_FRAME  = W_IN_DEF * H_IN_DEF * C_GROUPS_DEF;
    localparam int unsigned OUT_BEATS_PER_FRAME = W_OUT * H_OUT * C_GROUPS_DEF;

    typedef logic signed [DW-1:0] lane_t;
    typedef logic [BEAT_W-1:0]    beat_t;

    typedef enum logic [0:0] {
        StRun,
        StHold
    } pool_state_e;

    function automatic lane_t lane_max(lane_t a, lane_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic lane_t lane_get(beat_t beat, int unsigned k);
        return lane_t'(beat[k*DW +: DW]);
    endfunction

endpackage

// File: rtl/pool1_layer_if.sv
// pool1_layer_if: blob stream bundle (en/eop/rdy + one KPF*DW beat).
//   master : drives en, eop, data; receives rdy
//   slave  : receives en, eop, data; drives rdy
interface pool1_layer_if;
    logic            en;
    logic            eop;
    logic            rdy;
    pool1_pkg::beat_t data;

    modport master (output en, output eop, output data, input rdy);
    modport slave  (input en, input eop, input data, output rdy);
endinterface

// File: rtl/pool1_line_buf.sv
// pool1_line_buf: simple dual-port line buffer holding horizontal maxima of one even row.
//   clk_i                         : clock
//   wr_en_i, wr_addr_i, wr_data_i : synchronous write port
//   rd_en_i, rd_addr_i            : read request
//   rd_data_o                     : registered read data; holds until the next read
module pool1_line_buf
    import pool1_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned AddrW = 4
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  beat_t            wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output beat_t            rd_data_o
);

    beat_t mem_q [Depth];
    beat_t rd_data_q;

    // Contents need no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pool1_layer.sv
// pool1_layer: 2x2 stride-2 max pooling over a group-major/row/column blob stream.
//   clk, rst (async, active-low)
//   blob_din  (slave)  : input beats, rdy = !pend (registered)
//   blob_dout (master) : pooled beats, en pulses when pend && rdy
//   frame_err          : sticky, eop not coinciding with the final input position
// Optional: define POOL1_RELU_EN to clamp negative output lanes to zero.
module pool1_layer
    import pool1_pkg::*;
#(
    parameter int unsigned W_IN          = W_IN_DEF,
    parameter int unsigned H_IN          = H_IN_DEF,
    parameter int unsigned C_GROUPS      = C_GROUPS_DEF,
    parameter int unsigned LB_ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pool1_layer_if.slave  blob_din,
    pool1_layer_if.master blob_dout,
    output logic          frame_err
);

    localparam int unsigned ColW = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam int unsigned RowW = (H_IN > 1) ? $clog2(H_IN) : 1;
    localparam int unsigned GrpW = (C_GROUPS > 1) ? $clog2(C_GROUPS) : 1;

    pool_state_e     state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [GrpW-1:0] grp_q, grp_d;
    beat_t           hreg_q, hreg_d;
    beat_t           dout_q, dout_d;
    logic            dout_eop_q, dout_eop_d;
    logic            pend_q, pend_d;
    logic            din_rdy_q, din_rdy_d;
    logic            frame_err_q, frame_err_d;

    logic                     accept, fire, produce, early_eop;
    logic                     last_col, last_row, last_grp, last_pos;
    logic                     lb_wr_en, lb_rd_en;
    logic [LB_ADDR_WIDTH-1:0] lb_addr;
    beat_t                    lb_wdata, lb_rdata, pooled;

    assign accept    = blob_din.en & din_rdy_q;
    assign fire      = pend_q & blob_dout.rdy;
    assign last_col  = (col_q == ColW'(W_IN - 1));
    assign last_row  = (row_q == RowW'(H_IN - 1));
    assign last_grp  = (grp_q == GrpW'(C_GROUPS - 1));
    assign last_pos  = last_col & last_row & last_grp;
    assign early_eop = blob_din.eop & ~last_pos;
    assign lb_addr   = LB_ADDR_WIDTH'(col_q >> 1);

    // Per-lane signed maxima: horizontal pair for the line buffer, full window for output.
    always_comb begin : p_lanes
        lane_t m;
        m        = '0;
        lb_wdata = '0;
        pooled   = '0;
        for (int unsigned k = 0; k < KPF; k++) begin
            lb_wdata[k*DW +: DW] = lane_max(lane_get(hreg_q, k), lane_get(blob_din.data, k));
            m = lane_max(lane_max(lane_get(lb_rdata, k), lane_get(hreg_q, k)),
                         lane_get(blob_din.data, k));
`ifdef POOL1_RELU_EN
            if (m[DW-1]) begin
                m = '0;
            end
`endif
            pooled[k*DW +: DW] = m;
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        grp_d       = grp_q;
        hreg_d      = hreg_q;
        dout_d      = dout_q;
        dout_eop_d  = dout_eop_q;
        pend_d      = pend_q & ~fire;
        frame_err_d = frame_err_q;
        lb_wr_en    = 1'b0;
        lb_rd_en    = 1'b0;
        produce     = 1'b0;

        if (accept) begin
            if (blob_din.eop != last_pos) begin
                frame_err_d = 1'b1;
            end
            if (early_eop) begin
                // Truncated frame: restart at position 0 on the next beat.
                col_d = '0;
                row_d = '0;
                grp_d = '0;
            end else begin
                col_d = last_col ? '0 : col_q + 1'b1;
                if (last_col) begin
                    row_d = last_row ? '0 : row_q + 1'b1;
                    if (last_row) begin
                        grp_d = last_grp ? '0 : grp_q + 1'b1;
                    end
                end
            end

            unique case ({row_q[0], col_q[0]})
                2'b00: hreg_d = blob_din.data;
                2'b01: lb_wr_en = 1'b1;
                2'b10: begin
                    hreg_d   = blob_din.data;
                    lb_rd_en = 1'b1;
                end
                2'b11: begin
                    if (!early_eop) begin
                        produce    = 1'b1;
                        pend_d     = 1'b1;
                        dout_d     = pooled;
                        dout_eop_d = last_pos;
                    end
                end
                default: ;
            endcase
        end

        state_d = state_q;
        unique case (state_q)
            StRun:   if ((produce || pend_q) && !blob_dout.rdy) state_d = StHold;
            StHold:  if (fire) state_d = StRun;
            default: state_d = StRun;
        endcase

        din_rdy_d = ~pend_d & (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            col_q       <= '0;
            row_q       <= '0;
            grp_q       <= '0;
            hreg_q      <= '0;
            dout_q      <= '0;
            dout_eop_q  <= 1'b0;
            pend_q      <= 1'b0;
            din_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            grp_q       <= grp_d;
            hreg_q      <= hreg_d;
            dout_q      <= dout_d;
            dout_eop_q  <= dout_eop_d;
            pend_q      <= pend_d;
            din_rdy_q   <= din_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    pool1_line_buf #(
        .Depth (W_IN / 2),
        .AddrW (LB_ADDR_WIDTH)
    ) u_line_buf (
        .clk_i     (clk),
        .wr_en_i   (lb_wr_en),
        .wr_addr_i (lb_addr),
        .wr_data_i (lb_wdata),
        .rd_en_i   (lb_rd_en),
        .rd_addr_i (lb_addr),
        .rd_data_o (lb_rdata)
    );

    assign blob_din.rdy   = din_rdy_q;
    assign blob_dout.en   = fire;
    assign blob_dout.eop  = dout_eop_q;
    assign blob_dout.data = dout_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_pool1_layer.sv
// tb_pool1_layer: randomized self-checking bench for pool1_layer against a window-max model.
module tb_pool1_layer;
    import pool1_pkg::*;

    localparam int W  = int'(W_IN_DEF);
    localparam int H  = int'(H_IN_DEF);
    localparam int C  = int'(C_GROUPS_DEF);
    localparam int NB = int'(IN_BEATS_PER_FRAME);
    localparam int WO = int'(W_OUT);
    localparam int HO = int'(H_OUT);

    logic clk = 1'b0;
    logic rst_n;
    logic frame_err;

    pool1_layer_if din_if ();
    pool1_layer_if dout_if ();

    pool1_layer #(
        .W_IN          (W_IN_DEF),
        .H_IN          (H_IN_DEF),
        .C_GROUPS      (C_GROUPS_DEF),
        .LB_ADDR_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst_n),
        .blob_din  (din_if),
        .blob_dout (dout_if),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int    tests_run    = 0;
    int    tests_failed = 0;
    bit    collect      = 1'b0;
    bit    bp_hold      = 1'b0;
    bit    rdy_random   = 1'b0;
    beat_t frm [NB];
    beat_t exp_q [$];
    bit    exp_eop_q [$];
    beat_t got_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: each output lane is the signed max over its 2x2 input window.
    task automatic build_expected();
        beat_t o;
        int    m, v, idx;
        exp_q.delete();
        exp_eop_q.delete();
        got_q.delete();
        for (int g = 0; g < C; g++) begin
            for (int i = 0; i < HO; i++) begin
                for (int j = 0; j < WO; j++) begin
                    o = '0;
                    for (int k = 0; k < int'(KPF); k++) begin
                        m = -(1 << 30);
                        for (int dr = 0; dr < 2; dr++) begin
                            for (int dc = 0; dc < 2; dc++) begin
                                idx = (g * H + 2 * i + dr) * W + 2 * j + dc;
                                v   = int'(lane_get(frm[idx], k));
                                if (v > m) m = v;
                            end
                        end
`ifdef POOL1_RELU_EN
                        if (m < 0) m = 0;
`endif
                        o[k*16 +: 16] = m[15:0];
                    end
                    exp_q.push_back(o);
                    exp_eop_q.push_back(g == C - 1 && i == HO - 1 && j == WO - 1);
                end
            end
        end
    endtask

    task automatic fill_ramp();
        int r, c;
        for (int b = 0; b < NB; b++) begin
            r = (b / W) % H;
            c = b % W;
            for (int k = 0; k < int'(KPF); k++) begin
                frm[b][k*16 +: 16] = 16'(64 * r + 2 * c + k);
            end
        end
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++) begin
            frm[b] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Called and returns at posedge+1.
    task automatic send_beat(input beat_t d, input bit eop, input int duty);
        bit acc;
        int guard;
        while (int'($urandom_range(0, 99)) >= duty) begin
            @(posedge clk);
            #1;
        end
        din_if.en   = 1'b1;
        din_if.eop  = eop;
        din_if.data = d;
        guard = 0;
        do begin
            acc = din_if.rdy;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 2000);
        if (!acc) begin
            check("din_rdy_timeout", 128'(din_if.rdy), 128'(1));
            $fatal(1, "input stalled");
        end
        din_if.en  = 1'b0;
        din_if.eop = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int eop_idx, input int duty);
        for (int b = first; b <= last; b++) begin
            send_beat(frm[b], b == eop_idx, duty);
        end
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(tag, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        din_if.en  = 1'b0;
        din_if.eop = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check("rst_din_rdy", 128'(din_if.rdy), 128'(0));
        check("rst_dout_en", 128'(dout_if.en), 128'(0));
        check("rst_dout_eop", 128'(dout_if.eop), 128'(0));
        check("rst_dout_data", dout_if.data, 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 128'(din_if.rdy), 128'(1));
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && dout_if.en && collect) begin
            got_q.push_back(dout_if.data);
            check("out_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                check("out_data", dout_if.data, exp_q[0]);
                check("out_eop", 128'(dout_if.eop), 128'(exp_eop_q[0]));
                void'(exp_q.pop_front());
                void'(exp_eop_q.pop_front());
            end
        end
    end

    // Downstream ready driver.
    initial begin
        dout_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_hold)         dout_if.rdy = 1'b0;
            else if (rdy_random) dout_if.rdy = ($urandom_range(0, 1) == 1);
            else                 dout_if.rdy = 1'b1;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        beat_t    first;
        lane_t    neg_vals [4];
        int       win_idx [4];
        logic [15:0] neg_exp;

        din_if.en   = 1'b0;
        din_if.eop  = 1'b0;
        din_if.data = '0;
        rst_n       = 1'b1;
        #2;
        do_reset();

        // Ramp, gap-free, downstream always ready.
        fill_ramp();
        build_expected();
        collect = 1'b1;
        send_range(0, NB - 1, NB - 1, 100);
        drain("ramp_drain");
        check("ramp_frame_err", 128'(frame_err), 128'(0));

        // Random data with one all-negative window first, random downstream ready.
        fill_random();
        neg_vals = '{-16'sd5, -16'sd3, -16'sd7, -16'sd32768};
        win_idx  = '{0, 1, W, W + 1};
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < int'(KPF); k++) begin
                frm[win_idx[p]][k*16 +: 16] = neg_vals[p];
            end
        end
        build_expected();
        rdy_random = 1'b1;
        send_range(0, NB - 1, NB - 1, 100);
        rdy_random = 1'b0;
        drain("rand_drain");
        first = got_q[0];
`ifdef POOL1_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hFFFD;
`endif
        check("neg_window_lane0", 128'(first[15:0]), 128'(neg_exp));
        check("neg_window_lane7", 128'(first[127:112]), 128'(neg_exp));

        // Backpressure: stall the first result for 10 cycles.
        fill_ramp();
        build_expected();
        bp_hold     = 1'b1;
        dout_if.rdy = 1'b0;
        send_range(0, W + 1, NB - 1, 100);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_din_rdy", 128'(din_if.rdy), 128'(0));
            check("bp_dout_en", 128'(dout_if.en), 128'(0));
        end
        @(posedge clk);
        #1;
        bp_hold = 1'b0;
        send_range(W + 2, NB - 1, NB - 1, 100);
        drain("bp_drain");

        // Early eop on beat 100: flagged, then a clean frame from position 0.
        collect = 1'b0;
        fill_random();
        send_range(0, 99, 99, 100);
        repeat (5) @(posedge clk);
        #1;
        check("early_eop_frame_err", 128'(frame_err), 128'(1));
        fill_ramp();
        build_expected();
        collect = 1'b1;
        send_range(0, NB - 1, NB - 1, 100);
        drain("after_early_eop_drain");

        // Reset after 300 beats, then a full ramp frame.
        collect = 1'b0;
        fill_random();
        send_range(0, 299, -1, 100);
        do_reset();
        fill_ramp();
        build_expected();
        collect = 1'b1;
        send_range(0, NB - 1, NB - 1, 100);
        drain("after_reset_drain");
        check("after_reset_frame_err", 128'(frame_err), 128'(0));

        // Gapped input at 30% duty.
        build_expected();
        send_range(0, NB - 1, NB - 1, 30);
        drain("gapped_drain");
        check("gapped_frame_err", 128'(frame_err), 128'(0));

        // Final position without eop: flagged, counters wrap, data still correct.
        fill_random();
        build_expected();
        send_range(0, NB - 1, -1, 100);
        drain("no_eop_drain");
        check("no_eop_frame_err", 128'(frame_err), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
